mx_elem_expand: RTL and testbench

Expands one MX block of narrow sign-magnitude elements back into normalized wide floating-point fields (sign, biased exponent, augmented mantissa). It is the dequantization counterpart of the stochastic-rounding mantissa narrower. It sits on the read side of MX-quantized buffers, feeding wide-format arithmetic. A block is a shared E8M0 scale followed by `block_size` elements, streamed through a 2-stage valid/ready pipeline.

---
 rtl/mx_elem_expand.sv | 203 ++++++++++++++++++++
 tb/tb_mx_elem_expand.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mx_elem_expand.sv
// mx_elem_expand: expands one MX block (shared E8M0 scale + block_size
// sign-magnitude elements) into normalized wide floating-point fields.
// Two-stage valid/ready pipeline: stage 1 normalizes (leading-zero count),
// stage 2 forms exponent/mantissa and resolves the special cases.
module mx_elem_expand #(
  parameter int width_i    = 24,
  parameter int width_o    = 4,
  parameter int block_size = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [7:0]         i_scale,
  output logic               o_busy,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [width_o:0]   i_elem,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_sign,
  output logic [7:0]         o_exp,
  output logic [width_i-1:0] o_man,
  output logic               o_last,
  output logic               o_zero,
  output logic               o_ufl,
  output logic               o_nan
);

  localparam int CW  = (block_size > 1) ? $clog2(block_size) : 1;
  localparam int LZW = $clog2(width_o + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(block_size - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  // Leading-zero count over the magnitude; a zero magnitude reports width_o.
  function automatic logic [LZW-1:0] lzc_f(input logic [width_o-1:0] m);
    logic [LZW-1:0] n;
    n = LZW'(width_o);
    for (int i = 0; i < width_o; i++) begin
      if (m[i]) n = LZW'(width_o - 1 - i);
    end
    return n;
  endfunction

  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [7:0]        scale_q;
  logic              busy_q;

  logic              vld_p1_q;
  logic              sign_p1_q;
  logic [width_o-1:0] mag_p1_q;
  logic [LZW-1:0]    lzc_p1_q;
  logic              last_p1_q;

  logic              vld_p2_q;
  logic              sign_p2_q;
  logic [7:0]        exp_p2_q;
  logic [width_i-1:0] man_p2_q;
  logic              last_p2_q;
  logic              zero_p2_q;
  logic              ufl_p2_q;
  logic              nan_p2_q;

  logic              adv_p1;
  logic              adv_p2;
  logic              accept;

  logic signed [8:0] e_p2_d;
  logic [width_o-1:0] shifted_p2_d;
  logic [7:0]        exp_p2_d;
  logic [width_i-1:0] man_p2_d;
  logic              zero_p2_d;
  logic              ufl_p2_d;
  logic              nan_p2_d;

  // Stall control: stage 2 drains when downstream takes or it is empty,
  // stage 1 moves whenever stage 2 can absorb it.
  always_comb begin
    adv_p2  = !vld_p2_q || i_ready;
    adv_p1  = !vld_p1_q || adv_p2;
    o_ready = (state_q == ST_STREAM) && adv_p1;
    accept  = i_valid && o_ready;
  end

  // Block sequencing: latch scale on start, count accepts, wait for drain.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      scale_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            scale_q <= i_scale;
            cnt_q   <= '0;
            state_q <= ST_STREAM;
            busy_q  <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (accept) begin
            if (cnt_q == LAST_IDX) state_q <= ST_DRAIN;
            else                   cnt_q   <= cnt_q + CW'(1);
          end
        end
        ST_DRAIN: begin
          if (!vld_p1_q && !vld_p2_q) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy = busy_q;

  // ---- stage 1: capture element, normalize shift amount, last tag ----
  // Stage 1 occupancy.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       vld_p1_q <= 1'b0;
    else if (adv_p1) vld_p1_q <= accept;
  end

  // Stage 1 payload; only meaningful while vld_p1_q is set.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      sign_p1_q <= i_elem[width_o];
      mag_p1_q  <= i_elem[width_o-1:0];
      lzc_p1_q  <= lzc_f(i_elem[width_o-1:0]);
      last_p1_q <= (cnt_q == LAST_IDX);
    end
  end

  // ---- stage 2: exponent, mantissa and special-case resolution ----
  // Output fields with NaN > zero > underflow priority.
  always_comb begin
    e_p2_d       = $signed({1'b0, scale_q}) - $signed({{(9-LZW){1'b0}}, lzc_p1_q});
    shifted_p2_d = mag_p1_q << lzc_p1_q;
    exp_p2_d     = 8'h00;
    man_p2_d     = '0;
    zero_p2_d    = 1'b0;
    ufl_p2_d     = 1'b0;
    nan_p2_d     = 1'b0;
    if (scale_q == 8'hFF) begin
      nan_p2_d = 1'b1;
      exp_p2_d = 8'hFF;
    end else if (mag_p1_q == '0) begin
      zero_p2_d = 1'b1;
    end else if (e_p2_d <= 9'sd0) begin
      ufl_p2_d = 1'b1;
    end else begin
      exp_p2_d = e_p2_d[7:0];
      man_p2_d[width_i-1 -: width_o] = shifted_p2_d;
    end
  end

  // Stage 2 register; holds everything while downstream stalls.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_p2_q  <= 1'b0;
      sign_p2_q <= 1'b0;
      exp_p2_q  <= 8'h00;
      man_p2_q  <= '0;
      last_p2_q <= 1'b0;
      zero_p2_q <= 1'b0;
      ufl_p2_q  <= 1'b0;
      nan_p2_q  <= 1'b0;
    end else if (adv_p2) begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        sign_p2_q <= sign_p1_q;
        exp_p2_q  <= exp_p2_d;
        man_p2_q  <= man_p2_d;
        last_p2_q <= last_p1_q;
        zero_p2_q <= zero_p2_d;
        ufl_p2_q  <= ufl_p2_d;
        nan_p2_q  <= nan_p2_d;
      end
    end
  end

  assign o_valid = vld_p2_q;
  assign o_sign  = sign_p2_q;
  assign o_exp   = exp_p2_q;
  assign o_man   = man_p2_q;
  assign o_last  = last_p2_q;
  assign o_zero  = zero_p2_q;
  assign o_ufl   = ufl_p2_q;
  assign o_nan   = nan_p2_q;

endmodule

// File: tb/tb_mx_elem_expand.sv
// Testbench for mx_elem_expand (width_o=4, width_i=24, block_size=4).
module tb_mx_elem_expand;
  localparam int WI = 24;
  localparam int WO = 4;
  localparam int BS = 4;

  typedef logic [36:0] rec_t;

  logic          clk;
  logic          i_rst, i_start, i_valid, i_ready;
  logic [7:0]    i_scale;
  logic [WO:0]   i_elem;
  logic          o_busy, o_ready, o_valid, o_sign, o_last, o_zero, o_ufl, o_nan;
  logic [7:0]    o_exp;
  logic [WI-1:0] o_man;

  mx_elem_expand #(.width_i(WI), .width_o(WO), .block_size(BS)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_scale(i_scale),
    .o_busy(o_busy), .i_valid(i_valid), .o_ready(o_ready), .i_elem(i_elem),
    .o_valid(o_valid), .i_ready(i_ready), .o_sign(o_sign), .o_exp(o_exp),
    .o_man(o_man), .o_last(o_last), .o_zero(o_zero), .o_ufl(o_ufl), .o_nan(o_nan)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  rec_t expq[$];
  int   accq[$];
  rec_t got[$];
  logic [7:0] m_scale = 8'h00;
  int   m_idx  = 0;
  int   m_left = 0;
  bit   lat_chk = 1'b0;
  bit   bp_mode = 1'b0;

  function automatic rec_t pk(input logic s, input logic [7:0] e, input logic [23:0] m,
                              input logic l, input logic z, input logic u, input logic n);
    return {s, e, m, l, z, u, n};
  endfunction

  // Value-level model: value = mag * 2^(scale-127-3); normalize to 1.f * 2^k.
  function automatic rec_t model(input logic [7:0] sc, input logic [4:0] el, input logic last);
    int mag, k, t, e;
    mag = int'(el[3:0]);
    if (sc == 8'hFF) return pk(el[4], 8'hFF, 24'h0, last, 1'b0, 1'b0, 1'b1);
    if (mag == 0)    return pk(el[4], 8'h00, 24'h0, last, 1'b1, 1'b0, 1'b0);
    k = 0;
    t = mag;
    while (t > 1) begin
      t = t / 2;
      k++;
    end
    e = int'(sc) - (WO - 1 - k);
    if (e <= 0) return pk(el[4], 8'h00, 24'h0, last, 1'b0, 1'b1, 1'b0);
    return pk(el[4], 8'(e), 24'(mag * (1 << (23 - k))), last, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_got(input int idx, input rec_t exp);
    if (got.size() > idx) chk($sformatf("literal_out%0d", idx), 64'(got[idx]), 64'(exp));
    else begin
      n_cmp++;
      n_bad++;
      $display("FAIL literal_out%0d: got no output, expected %h", idx, exp);
    end
  endtask

  // Per-cycle compare process: model scoreboard, stall stability, ready rules.
  initial begin : compare
    rec_t cur, prev, e;
    bit   prev_hold;
    int   a;
    prev_hold = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      cur = pk(o_sign, o_exp, o_man, o_last, o_zero, o_ufl, o_nan);
      if (i_rst) begin
        chk("reset_outputs", 64'({o_valid, o_ready, o_busy, cur}), 64'd0);
        expq.delete();
        accq.delete();
        m_left = 0;
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) chk("stall_stable", 64'({o_valid, cur}), 64'({1'b1, prev}));
        if (i_valid && m_left == 0) chk("ready_closed", 64'(o_ready), 64'd0);
        if (o_valid && !i_ready && expq.size() >= 2) chk("ready_full", 64'(o_ready), 64'd0);
        if (o_valid && i_ready) begin
          if (expq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_output: got %h, expected none", cur);
          end else begin
            e = expq.pop_front();
            a = accq.pop_front();
            chk("output", 64'(cur), 64'(e));
            if (lat_chk) chk("latency", 64'(cyc - a), 64'd2);
          end
          got.push_back(cur);
        end
        if (i_valid && o_ready && m_left > 0) begin
          expq.push_back(model(m_scale, i_elem, 1'(m_idx == BS - 1)));
          accq.push_back(cyc);
          m_idx++;
          m_left--;
        end
        prev_hold = o_valid && !i_ready;
        prev = cur;
      end
    end
  end

  // Downstream ready: constant high, or a toggling pattern with 5-cycle stalls.
  initial begin : ready_drv
    logic [23:0] pat;
    int bi;
    pat = 24'b1010_1100_0001_1010_0000_1101;
    bi = 0;
    i_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (bp_mode) begin
        i_ready = pat[bi % 24];
        bi++;
      end else begin
        i_ready = 1'b1;
      end
    end
  end

  task automatic start_block(input logic [7:0] sc);
    i_start = 1'b1;
    i_scale = sc;
    m_scale = sc;
    m_idx   = 0;
    m_left  = BS;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic send(input logic [4:0] el);
    int t;
    t = 0;
    i_valid = 1'b1;
    i_elem  = el;
    while (1) begin
      #3;
      if (o_ready) begin
        @(negedge clk);
        break;
      end
      @(negedge clk);
      t++;
      if (t > 200) begin
        n_cmp++;
        n_bad++;
        $display("FAIL send_timeout: got o_ready=0 for 200 cycles, expected accept");
        break;
      end
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (1) begin
      #3;
      if (expq.size() == 0 && !o_busy) begin
        @(negedge clk);
        break;
      end
      @(negedge clk);
      t++;
      if (t > 300) begin
        n_cmp++;
        n_bad++;
        $display("FAIL idle_timeout: got busy=%0d pending=%0d, expected idle", o_busy, expq.size());
        break;
      end
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1);
  end

  initial begin : stim
    int base;
    i_rst = 1'b1; i_start = 1'b0; i_valid = 1'b0; i_scale = 8'h00; i_elem = '0;
    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);

    // Normal elements, scale 127
    lat_chk = 1'b1;
    base = got.size();
    start_block(8'd127);
    send(5'b0_1000); send(5'b0_0001); send(5'b1_0110); send(5'b0_0111);
    i_valid = 1'b0;
    wait_idle();
    lat_chk = 1'b0;
    chk_got(base + 0, pk(1'b0, 8'd127, 24'h800000, 1'b0, 1'b0, 1'b0, 1'b0));
    chk_got(base + 1, pk(1'b0, 8'd124, 24'h800000, 1'b0, 1'b0, 1'b0, 1'b0));
    chk_got(base + 2, pk(1'b1, 8'd126, 24'hC00000, 1'b0, 1'b0, 1'b0, 1'b0));
    chk_got(base + 3, pk(1'b0, 8'd126, 24'hE00000, 1'b1, 1'b0, 1'b0, 1'b0));
    chk("busy_after_drain", 64'(o_busy), 64'd0);

    // Zero and underflow, scale 2
    base = got.size();
    start_block(8'd2);
    send(5'b0_0000); send(5'b0_0001); send(5'b0_0100); send(5'b1_1000);
    i_valid = 1'b0;
    wait_idle();
    chk_got(base + 0, pk(1'b0, 8'd0, 24'h000000, 1'b0, 1'b1, 1'b0, 1'b0));
    chk_got(base + 1, pk(1'b0, 8'd0, 24'h000000, 1'b0, 1'b0, 1'b1, 1'b0));
    chk_got(base + 2, pk(1'b0, 8'd1, 24'h800000, 1'b0, 1'b0, 1'b0, 1'b0));
    chk_got(base + 3, pk(1'b1, 8'd2, 24'h800000, 1'b1, 1'b0, 1'b0, 1'b0));

    // NaN scale
    base = got.size();
    start_block(8'hFF);
    send(5'b0_0000); send(5'b1_0101); send(5'b0_1111); send(5'b1_0000);
    i_valid = 1'b0;
    wait_idle();
    chk_got(base + 0, pk(1'b0, 8'hFF, 24'h0, 1'b0, 1'b0, 1'b0, 1'b1));
    chk_got(base + 1, pk(1'b1, 8'hFF, 24'h0, 1'b0, 1'b0, 1'b0, 1'b1));
    chk_got(base + 2, pk(1'b0, 8'hFF, 24'h0, 1'b0, 1'b0, 1'b0, 1'b1));
    chk_got(base + 3, pk(1'b1, 8'hFF, 24'h0, 1'b1, 1'b0, 1'b0, 1'b1));

    // Backpressure with continuous i_valid
    bp_mode = 1'b1;
    base = got.size();
    start_block(8'd130);
    send(5'b0_0011); send(5'b1_1111); send(5'b0_0101); send(5'b1_0010);
    i_valid = 1'b0;
    wait_idle();
    bp_mode = 1'b0;
    chk("bp_count", 64'(got.size() - base), 64'd4);
    chk_got(base + 0, pk(1'b0, 8'd128, 24'hC00000, 1'b0, 1'b0, 1'b0, 1'b0));
    chk_got(base + 1, pk(1'b1, 8'd130, 24'hF00000, 1'b0, 1'b0, 1'b0, 1'b0));

    // Protocol boundaries: start in STREAM, 5th element, start in DRAIN
    base = got.size();
    start_block(8'd127);
    send(5'b0_1000);
    i_start = 1'b1;
    i_scale = 8'hFF;
    send(5'b0_0001);
    i_start = 1'b0;
    send(5'b1_0110);
    send(5'b0_0111);
    i_start = 1'b1;
    i_scale = 8'd2;
    i_elem  = 5'b0_1111;
    @(negedge clk);
    i_start = 1'b0;
    repeat (2) @(negedge clk);
    i_valid = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    chk("start_in_drain_ignored", 64'(o_busy), 64'd0);
    chk("protocol_count", 64'(got.size() - base), 64'd4);
    chk_got(base + 1, pk(1'b0, 8'd124, 24'h800000, 1'b0, 1'b0, 1'b0, 1'b0));
    chk_got(base + 3, pk(1'b0, 8'd126, 24'hE00000, 1'b1, 1'b0, 1'b0, 1'b0));

    // Reset mid-block, then a fresh block
    start_block(8'd127);
    send(5'b0_1000);
    send(5'b0_0001);
    i_valid = 1'b0;
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", 64'({o_busy, o_valid, o_ready}), 64'd0);
    base = got.size();
    start_block(8'd127);
    send(5'b0_1000); send(5'b0_0001); send(5'b1_0110); send(5'b0_0111);
    i_valid = 1'b0;
    wait_idle();
    chk("reset_block_count", 64'(got.size() - base), 64'd4);
    chk_got(base + 0, pk(1'b0, 8'd127, 24'h800000, 1'b0, 1'b0, 1'b0, 1'b0));
    chk_got(base + 3, pk(1'b0, 8'd126, 24'hE00000, 1'b1, 1'b0, 1'b0, 1'b0));

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
